// File: rtl/tmds_decoder_if.sv
// Stream bundle between a TMDS channel deserializer and tmds_decoder.
// No valid/ready: one word moves every pixel_clk cycle with no backpressure; bitslip is the only return request.
interface tmds_decoder_if;
  logic [9:0] tmds_word;
  logic       bitslip;
  logic       aligned;
  logic [7:0] data_out;
  logic       c0;
  logic       c1;
  logic       de_out;

  modport master (
    output tmds_word,
    input  bitslip, aligned, data_out, c0, c1, de_out
  );

  modport slave (
    input  tmds_word,
    output bitslip, aligned, data_out, c0, c1, de_out
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: word-boundary alignment FSM plus 2-stage symbol decode.
// Optional lock-loss counter port err_cnt is built when TMDS_DEC_ERR_CNT_EN is defined.
module tmds_decoder #(
  parameter int SEARCH_WIN = 4096,
  parameter int TOKEN_RUN  = 8,
  parameter int SLIP_GAP   = 16
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  tmds_decoder_if.slave bus,
  output logic [1:0]  dbg_state_o
`ifdef TMDS_DEC_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int WIN_W = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
  localparam int RUN_W = (TOKEN_RUN  > 1) ? $clog2(TOKEN_RUN)  : 1;
  localparam int GAP_W = (SLIP_GAP   > 1) ? $clog2(SLIP_GAP)   : 1;

  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(SEARCH_WIN - 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TOKEN_RUN - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SLIP_GAP - 1);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_VERIFY    = 2'd1,
    ST_SLIP_WAIT = 2'd2,
    ST_LOCKED    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             slip_d;

  logic [9:0] w1_q;
  logic       bitslip_q;
  logic       aligned_q;
  logic [7:0] data_q;
  logic       de_q;
  logic [1:0] c_q;
  logic [1:0] last_c_q;

  logic       tok;
  logic [1:0] tok_c;
  logic [7:0] d_raw;
  logic [7:0] d_dec;

  // Control tokens, encoded as {c1, c0}.
  always_comb begin
    tok   = 1'b1;
    tok_c = 2'b00;
    case (w1_q)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        tok   = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d_raw    = w1_q[9] ? ~w1_q[7:0] : w1_q[7:0];
    d_dec    = 8'h00;
    d_dec[0] = d_raw[0];
    for (int i = 1; i < 8; i++) begin
      d_dec[i] = w1_q[8] ? (d_raw[i] ^ d_raw[i-1]) : ~(d_raw[i] ^ d_raw[i-1]);
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    run_d   = run_q;
    gap_d   = gap_q;
    slip_d  = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (tok) begin
          win_d = '0;
          if (TOKEN_RUN <= 1) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_VERIFY;
            run_d   = RUN_W'(1);
          end
        end else if (win_q == WIN_MAX) begin
          state_d = ST_SLIP_WAIT;
          slip_d  = 1'b1;
          win_d   = '0;
          gap_d   = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      ST_VERIFY: begin
        if (tok) begin
          if (run_q == RUN_MAX) begin
            state_d = ST_LOCKED;
            run_d   = '0;
            win_d   = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          state_d = ST_SEARCH;
          run_d   = '0;
          win_d   = '0;
        end
      end
      ST_SLIP_WAIT: begin
        if (gap_q == GAP_MAX) begin
          state_d = ST_SEARCH;
          gap_d   = '0;
          win_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_LOCKED: begin
        if (tok) begin
          win_d = '0;
        end else if (win_q == WIN_MAX) begin
          state_d = ST_SEARCH;
          win_d   = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      default: begin
        state_d = ST_SEARCH;
        win_d   = '0;
        run_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q   <= ST_SEARCH;
      win_q     <= '0;
      run_q     <= '0;
      gap_q     <= '0;
      w1_q      <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      run_q     <= run_d;
      gap_q     <= gap_d;
      w1_q      <= bus.tmds_word;
      bitslip_q <= slip_d;
      aligned_q <= (state_q == ST_LOCKED);
    end
  end

  // Stage 2 is gated by the registered aligned flag, so output resumes one word after it rises.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      data_q   <= 8'h00;
      de_q     <= 1'b0;
      c_q      <= 2'b00;
      last_c_q <= 2'b00;
    end else begin
      if (tok) begin
        last_c_q <= tok_c;
      end
      if (!aligned_q) begin
        data_q <= 8'h00;
        de_q   <= 1'b0;
        c_q    <= 2'b00;
      end else if (tok) begin
        data_q <= 8'h00;
        de_q   <= 1'b0;
        c_q    <= tok_c;
      end else begin
        data_q <= d_dec;
        de_q   <= 1'b1;
        c_q    <= last_c_q;
      end
    end
  end

`ifdef TMDS_DEC_ERR_CNT_EN
  logic [15:0] err_q;
  logic        lock_loss;

  assign lock_loss = (state_q == ST_LOCKED) && !tok && (win_q == WIN_MAX);

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      err_q <= 16'h0000;
    end else if (lock_loss && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'h0001;
    end
  end

  assign err_cnt = err_q;
`endif

  assign bus.bitslip  = bitslip_q;
  assign bus.aligned  = aligned_q;
  assign bus.data_out = data_q;
  assign bus.de_out   = de_q;
  assign bus.c0       = c_q[0];
  assign bus.c1       = c_q[1];
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, token/data decode, lock loss, slip cadence, resets.
module tb_tmds_decoder;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] PAT55 = 10'b0101010101;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
`ifdef TMDS_DEC_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  tmds_decoder_if dec_if ();

  tmds_decoder dut (
    .pixel_clk   (clk),
    .sys_rst     (rst),
    .bus         (dec_if.slave),
    .dbg_state_o (dbg_state)
`ifdef TMDS_DEC_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
  endtask

  // Called just after an edge, so the next edge is the first normal evaluation.
  task automatic release_with(input logic [9:0] w);
    rst = 1'b0;
    dec_if.tmds_word = w;
  endtask

  task automatic lock_up(input string tag);
    apply_reset(2);
    release_with(TOK00);
    repeat (10) tick();
    check(tag, 32'(dec_if.aligned), 32'd1);
  endtask

  logic [9:0] tok_words[4];
  logic [1:0] tok_exp[4];
  logic [9:0] dat_words[5];
  logic [7:0] dat_exp[5];

  initial begin
    int slips;
    int bad;
    int first_e;
    int second_e;

    tok_words = '{TOK01, TOK10, TOK00, TOK11};
    tok_exp   = '{2'b01, 2'b10, 2'b00, 2'b11};
    dat_words = '{10'b0100000001, 10'b1011111110, 10'b1100000000, 10'b0000000000, PAT55};
    dat_exp   = '{8'h03, 8'hFD, 8'h01, 8'hFE, 8'hFF};

    rst = 1'b1;
    dec_if.tmds_word = 10'd0;
    apply_reset(3);
    check("rst_state",   32'(dbg_state), 32'd0);
    check("rst_aligned", 32'(dec_if.aligned), 32'd0);
    check("rst_bitslip", 32'(dec_if.bitslip), 32'd0);
    check("rst_data",    32'(dec_if.data_out), 32'd0);
    check("rst_de",      32'(dec_if.de_out), 32'd0);
    check("rst_c",       32'({dec_if.c1, dec_if.c0}), 32'd0);
`ifdef TMDS_DEC_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Continuous TOK00 from the first edge: lock on edge 9, aligned on edge 10.
    release_with(TOK00);
    slips = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (dec_if.bitslip) slips++;
      if (e == 8) check("verify_state_e8", 32'(dbg_state), 32'd1);
      if (e == 9) begin
        check("locked_state_e9", 32'(dbg_state), 32'd3);
        check("aligned_e9", 32'(dec_if.aligned), 32'd0);
      end
      if (e == 10) check("aligned_e10", 32'(dec_if.aligned), 32'd1);
    end
    check("lock_no_bitslip", 32'(slips), 32'd0);
    tick();
    check("tok00_c", 32'({dec_if.c1, dec_if.c0}), 32'd0);
    check("tok00_de", 32'(dec_if.de_out), 32'd0);
    check("tok00_data", 32'(dec_if.data_out), 32'd0);

    for (int i = 0; i < 4; i++) begin
      dec_if.tmds_word = tok_words[i];
      tick();
      tick();
      check($sformatf("tok_c_%0d", i), 32'({dec_if.c1, dec_if.c0}), 32'(tok_exp[i]));
      check($sformatf("tok_de_%0d", i), 32'(dec_if.de_out), 32'd0);
    end

    // Data words pipelined back to back; c1c0 must hold the last token (11).
    for (int i = 0; i < 5; i++) exp_q.push_back(dat_exp[i]);
    dec_if.tmds_word = dat_words[0];
    tick();
    check("latency_de_still_0", 32'(dec_if.de_out), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] exp_b;
      dec_if.tmds_word = (i < 5) ? dat_words[i] : TOK11;
      tick();
      exp_b = exp_q.pop_front();
      check($sformatf("data_%0d", i - 1), 32'(dec_if.data_out), 32'(exp_b));
      check($sformatf("de_%0d", i - 1), 32'(dec_if.de_out), 32'd1);
      check($sformatf("c_hold_%0d", i - 1), 32'({dec_if.c1, dec_if.c0}), 32'd3);
    end
    check("still_locked", 32'(dbg_state), 32'd3);

    // Reset while LOCKED and emitting data.
    dec_if.tmds_word = PAT55;
    tick();
    tick();
    check("pre_rst_de", 32'(dec_if.de_out), 32'd1);
    rst = 1'b1;
    tick();
    check("midlock_rst_state", 32'(dbg_state), 32'd0);
    check("midlock_rst_aligned", 32'(dec_if.aligned), 32'd0);
    check("midlock_rst_de", 32'(dec_if.de_out), 32'd0);
    check("midlock_rst_data", 32'(dec_if.data_out), 32'd0);

    // Lock loss after 4096 data words without a token.
    lock_up("relock_aligned");
    dec_if.tmds_word = PAT55;
    slips = 0;
    bad = 0;
    for (int e = 1; e <= 4096; e++) begin
      tick();
      if (dec_if.bitslip) slips++;
      if (!dec_if.aligned) bad++;
    end
    check("loss_pre_state", 32'(dbg_state), 32'd3);
    check("loss_pre_aligned_drops", 32'(bad), 32'd0);
    tick();
    check("loss_state", 32'(dbg_state), 32'd0);
    check("loss_aligned_lags", 32'(dec_if.aligned), 32'd1);
    check("loss_no_bitslip", 32'(dec_if.bitslip), 32'd0);
    tick();
    check("loss_aligned", 32'(dec_if.aligned), 32'd0);
    check("loss_last_data", 32'(dec_if.data_out), 32'hFF);
    tick();
    check("loss_data_forced", 32'(dec_if.data_out), 32'd0);
    check("loss_de_forced", 32'(dec_if.de_out), 32'd0);
    check("loss_c_forced", 32'({dec_if.c1, dec_if.c0}), 32'd0);
    check("loss_slips", 32'(slips), 32'd0);
`ifdef TMDS_DEC_ERR_CNT_EN
    check("loss_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Reset in the middle of VERIFY; lock needs a fresh run.
    apply_reset(2);
    release_with(TOK00);
    repeat (5) tick();
    check("midverify_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    tick();
    check("midverify_rst_state", 32'(dbg_state), 32'd0);
    check("midverify_rst_aligned", 32'(dec_if.aligned), 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 9) check("fresh_aligned_e9", 32'(dec_if.aligned), 32'd0);
      if (e == 10) check("fresh_aligned_e10", 32'(dec_if.aligned), 32'd1);
    end

    // Never a token: bitslip on edges 4096 and 4096+4112.
    apply_reset(2);
    release_with(PAT55);
    slips = 0;
    bad = 0;
    first_e = 0;
    second_e = 0;
    for (int e = 1; e <= 8210; e++) begin
      tick();
      if (dec_if.bitslip) begin
        slips++;
        if (slips == 1) first_e = e;
        else if (slips == 2) second_e = e;
      end
      if (dec_if.aligned || dec_if.de_out || dec_if.c0 || dec_if.c1 || (dec_if.data_out != 8'h00)) bad++;
      if (e == 4096) check("slip_wait_state", 32'(dbg_state), 32'd2);
    end
    check("slip_count", 32'(slips), 32'd2);
    check("slip_first_edge", 32'(first_e), 32'd4096);
    check("slip_second_edge", 32'(second_e), 32'd8208);
    check("slip_outputs_quiet", 32'(bad), 32'd0);
    check("slip_wait_state_end", 32'(dbg_state), 32'd2);

    // Reset in the middle of SLIP_WAIT.
    rst = 1'b1;
    tick();
    check("midslip_rst_state", 32'(dbg_state), 32'd0);
    check("midslip_rst_bitslip", 32'(dec_if.bitslip), 32'd0);
    check("midslip_rst_aligned", 32'(dec_if.aligned), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL provide parameter SEARCH_WIN, default 4096: cycles allowed without a control token before a slip (SEARCH) or a lock loss (LOCKED).
REQ-002 SHALL provide parameter TOKEN_RUN, default 8: consecutive control tokens required to declare lock.
REQ-003 SHALL provide parameter SLIP_GAP, default 16: quiet cycles after each bitslip pulse, letting the deserializer settle.
REQ-004 pixel_clk  input  1  sole clock; one TMDS word per cycle.
REQ-005 sys_rst  input  1  reset; synchronous, active-high.
REQ-006 tmds_word  input  10  parallel word from the channel deserializer, bit0 first on the wire.
REQ-007 bitslip  output  1  single-cycle request to the deserializer to shift the word boundary by one bit.
REQ-008 aligned  output  1  high while the word boundary is locked.
REQ-009 data_out  output  8  decoded video byte.
REQ-010 c0, c1  output  1 each  decoded control bits (hsync/vsync on channel 0).
REQ-011 de_out  output  1  high for data words, low for control tokens.

Function
REQ-012 SHALL register tmds_word into stage-1 (w1), then decode w1 into registered outputs (stage-2): latency 2 cycles, one word/cycle, no stalls.
REQ-013 SHALL decode control tokens 1101010100->c1c0=00, 0010101011->01, 0101010100->10, 1010101011->11, with de_out=0 and data_out=0.
REQ-014 SHALL decode any other word with de_out=1, c0/c1 held at last token value: d=w1[9]?~w1[7:0]:w1[7:0]; D0=d0; for n=1..7 Dn=dn^dn-1 if w1[8]=1, else Dn=~(dn^dn-1).
REQ-015 SHALL force data_out, c0, c1, de_out to 0 on any stage-2 update while aligned=0.
REQ-016 FSM states SEARCH, VERIFY, SLIP_WAIT, LOCKED; token detection uses w1.
REQ-017 SEARCH: token -> VERIFY with run=1; else window count increments; at SEARCH_WIN-1 without token -> pulse bitslip for 1 cycle, enter SLIP_WAIT.
REQ-018 SLIP_WAIT: ignore w1 for SLIP_GAP cycles, then SEARCH with window count cleared.
REQ-019 VERIFY: token with run=TOKEN_RUN-1 -> LOCKED; token otherwise -> run+1; non-token -> SEARCH without slip, counters cleared.
REQ-020 LOCKED: any token clears the window count; window reaching SEARCH_WIN-1 without token -> SEARCH (lock loss), no bitslip on that cycle.
REQ-021 aligned SHALL be registered (state==LOCKED), changing one cycle after the state transition.
REQ-022 bitslip SHALL never assert in two consecutive cycles nor outside the SEARCH->SLIP_WAIT transition.
REQ-023 all counters SHALL be sized for their parameter and never wrap; each is cleared on every state entry.

Reset
REQ-024 sys_rst high at a clock edge SHALL set state SEARCH, clear all counters and w1, and drive bitslip, aligned, data_out, c0, c1, de_out to 0, including mid-VERIFY, mid-SLIP_WAIT and mid-LOCKED.
REQ-025 first normal evaluation SHALL occur on the first edge after sys_rst is sampled low.

Configuration
REQ-026 macro TMDS_DEC_ERR_CNT_EN defined: SHALL add output err_cnt [15:0], reset 0, +1 per lock-loss event (REQ-020), saturating at 16'hFFFF.
REQ-027 macro undefined: port err_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 reset, then 10'b1101010100 every cycle from cycle 1 -> aligned=1 after the 10th edge, bitslip never high, c1c0=00, de_out=0.
REQ-029 locked, apply 10'b0100000001 then 10'b1011111110 -> data_out=8'h03 then 8'hFD, de_out=1, 2-cycle latency.
REQ-030 constant 10'b0101010101 from reset -> bitslip high for exactly 1 cycle every SEARCH_WIN+SLIP_GAP cycles (4096+16 at defaults), aligned stays 0, outputs 0.
REQ-031 locked, then 4096 data words with no token -> aligned falls, outputs forced 0; with TMDS_DEC_ERR_CNT_EN, err_cnt=1.
REQ-032 5 tokens then sys_rst high 1 cycle, then tokens continue -> state SEARCH, aligned=0; lock needs a fresh run of 8 tokens.
